// File: rtl/vending_pkg.sv
// vending_pkg: states, event codes and index-width helpers for vending_controller.
// The optional restock mode is built in when VEND_ADMIN_EN is defined.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEND,
        ST_CHANGE,
        ST_ADMIN
    } state_e;

    localparam logic [2:0] EV_NONE        = 3'd0;
    localparam logic [2:0] EV_COIN_OK     = 3'd1;
    localparam logic [2:0] EV_VEND        = 3'd2;
    localparam logic [2:0] EV_SOLD_OUT    = 3'd3;
    localparam logic [2:0] EV_NO_FUNDS    = 3'd4;
    localparam logic [2:0] EV_REJECT      = 3'd5;
    localparam logic [2:0] EV_CHANGE_DONE = 3'd6;
    localparam logic [2:0] EV_ADMIN       = 3'd7;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int item_w(input int n_items);
        return idx_w(n_items);
    endfunction

    function automatic int coin_w(input int n_coins);
        return idx_w(n_coins);
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: greedy largest-first coin selector and hopper handshake.
// Reports the value taken each handshake so the core can decrement credit.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int N_COINS = 3,
    parameter int MONEY_W = 12,
    parameter logic [N_COINS*MONEY_W-1:0] COIN_VAL = {12'd50, 12'd100, 12'd500}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MONEY_W-1:0]          credit,
    input  logic                        change_ready,
    output logic                        change_valid,
    output logic [coin_w(N_COINS)-1:0]  change_coin,
    output logic                        take,
    output logic [MONEY_W-1:0]          dec,
    output logic                        hit
);

    localparam int CW = coin_w(N_COINS);

    logic [MONEY_W-1:0] remain;
    logic [CW-1:0]      pick;

    always_comb begin
        take = change_valid & change_ready;
        dec  = '0;
        if (take) begin
            for (int i = 0; i < N_COINS; i++) begin
                if (change_coin == CW'(i)) dec = COIN_VAL[i*MONEY_W +: MONEY_W];
            end
        end
        remain = credit - dec;
        // Scan downwards so the largest fitting coin (lowest index) wins.
        hit  = 1'b0;
        pick = '0;
        for (int i = N_COINS - 1; i >= 0; i--) begin
            if (COIN_VAL[i*MONEY_W +: MONEY_W] <= remain) begin
                hit  = 1'b1;
                pick = CW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            change_valid <= 1'b0;
            change_coin  <= '0;
        end else if (start || take) begin
            change_valid <= hit;
            change_coin  <= pick;
        end
    end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: credit/stock engine with dispense and change handshakes.
// Define VEND_ADMIN_EN to build in the restock (ADMIN) mode.
module vending_controller
    import vending_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int N_COINS    = 3,
    parameter int MONEY_W    = 12,
    parameter int STOCK_W    = 4,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICE =
        {12'd300, 12'd250, 12'd200, 12'd150},
    parameter logic [N_COINS*MONEY_W-1:0] COIN_VAL =
        {12'd50, 12'd100, 12'd500},
    parameter int INIT_STOCK = 5,
    parameter int MAX_CREDIT = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_COINS-1:0]          coin_in,
    input  logic [N_ITEMS-1:0]          sel,
    input  logic                        cancel,
    input  logic                        admin_mode,
    input  logic                        dispense_ready,
    input  logic                        change_ready,
    output logic [MONEY_W-1:0]          credit,
    output logic                        dispense_valid,
    output logic [item_w(N_ITEMS)-1:0]  dispense_item,
    output logic                        change_valid,
    output logic [coin_w(N_COINS)-1:0]  change_coin,
    output logic [N_ITEMS*STOCK_W-1:0]  stock,
    output logic                        event_valid,
    output logic [2:0]                  event_code
);

    localparam int IW = item_w(N_ITEMS);
    localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);
    localparam logic [MONEY_W:0]   MAX_C  = (MONEY_W+1)'(MAX_CREDIT);

    state_e                     state, state_n;
    logic [MONEY_W-1:0]         credit_n;
    logic [N_ITEMS*STOCK_W-1:0] stock_n;
    logic                       dv_n;
    logic [IW-1:0]              di_n;
    logic                       ev_v_n;
    logic [2:0]                 ev_c_n;
    logic                       start;

    logic                       sel_any, coin_any;
    logic [IW-1:0]              sel_idx;
    logic [MONEY_W-1:0]         item_price, coin_val;
    logic [STOCK_W-1:0]         item_stock;
    logic [MONEY_W:0]           sum;

    logic                       take, hit;
    logic [MONEY_W-1:0]         dec;

    change_dispenser #(
        .N_COINS  (N_COINS),
        .MONEY_W  (MONEY_W),
        .COIN_VAL (COIN_VAL)
    ) u_change (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .credit       (credit),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .take         (take),
        .dec          (dec),
        .hit          (hit)
    );

    // Lowest set bit wins for both select and coin pulses.
    always_comb begin
        sel_any    = |sel;
        sel_idx    = '0;
        item_price = '0;
        item_stock = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_idx    = IW'(i);
                item_price = PRICE[i*MONEY_W +: MONEY_W];
                item_stock = stock[i*STOCK_W +: STOCK_W];
            end
        end
        coin_any = |coin_in;
        coin_val = '0;
        for (int i = N_COINS - 1; i >= 0; i--) begin
            if (coin_in[i]) coin_val = COIN_VAL[i*MONEY_W +: MONEY_W];
        end
        sum = {1'b0, credit} + {1'b0, coin_val};
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        stock_n  = stock;
        dv_n     = dispense_valid;
        di_n     = dispense_item;
        ev_v_n   = 1'b0;
        ev_c_n   = event_code;
        start    = 1'b0;
        unique case (state)
            ST_IDLE: begin
`ifdef VEND_ADMIN_EN
                if (admin_mode) begin
                    state_n = ST_ADMIN;
                    ev_v_n  = 1'b1;
                    ev_c_n  = EV_ADMIN;
                end else
`endif
                if (cancel) begin
                    if (credit != '0 && hit) begin
                        start   = 1'b1;
                        state_n = ST_CHANGE;
                    end
                end else if (sel_any) begin
                    ev_v_n = 1'b1;
                    if (item_stock == '0) begin
                        ev_c_n = EV_SOLD_OUT;
                    end else if (credit < item_price) begin
                        ev_c_n = EV_NO_FUNDS;
                    end else begin
                        credit_n = credit - item_price;
                        stock_n[sel_idx*STOCK_W +: STOCK_W] = item_stock - 1'b1;
                        dv_n    = 1'b1;
                        di_n    = sel_idx;
                        ev_c_n  = EV_VEND;
                        state_n = ST_VEND;
                    end
                end else if (coin_any) begin
                    ev_v_n = 1'b1;
                    if (sum <= MAX_C) begin
                        credit_n = sum[MONEY_W-1:0];
                        ev_c_n   = EV_COIN_OK;
                    end else begin
                        ev_c_n = EV_REJECT;
                    end
                end
            end
            ST_VEND: begin
                if (coin_any) begin
                    ev_v_n = 1'b1;
                    ev_c_n = EV_REJECT;
                end
                if (dispense_ready) begin
                    dv_n    = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (coin_any) begin
                    ev_v_n = 1'b1;
                    ev_c_n = EV_REJECT;
                end
                // A finished payout outranks a coin rejected in the same cycle.
                if (take) begin
                    credit_n = credit - dec;
                    if (credit_n == '0) begin
                        ev_v_n  = 1'b1;
                        ev_c_n  = EV_CHANGE_DONE;
                        state_n = ST_IDLE;
                    end else if (!hit) begin
                        state_n = ST_IDLE;
                    end
                end
            end
`ifdef VEND_ADMIN_EN
            ST_ADMIN: begin
                if (!admin_mode) begin
                    state_n = ST_IDLE;
                end else if (cancel) begin
                    credit_n = '0;
                end else if (sel_any) begin
                    if (item_stock != '1)
                        stock_n[sel_idx*STOCK_W +: STOCK_W] = item_stock + 1'b1;
                end else if (coin_any) begin
                    ev_v_n = 1'b1;
                    ev_c_n = EV_REJECT;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

`ifndef VEND_ADMIN_EN
    logic unused_admin;
    assign unused_admin = admin_mode;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            credit         <= '0;
            stock          <= {N_ITEMS{INIT_S}};
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            event_valid    <= 1'b0;
            event_code     <= EV_NONE;
        end else begin
            state          <= state_n;
            credit         <= credit_n;
            stock          <= stock_n;
            dispense_valid <= dv_n;
            dispense_item  <= di_n;
            event_valid    <= ev_v_n;
            event_code     <= ev_c_n;
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed and random stimulus against a queue-based model.
// Honours VEND_ADMIN_EN the same way as the design.
module tb_vending_controller;

    localparam int M_IDLE = 0;
    localparam int M_VEND = 1;
    localparam int M_CHG  = 2;
    localparam int M_ADM  = 3;
`ifdef VEND_ADMIN_EN
    localparam bit ADMIN_ON = 1'b1;
`else
    localparam bit ADMIN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  coin_in = '0;
    logic [3:0]  sel = '0;
    logic        cancel = 1'b0;
    logic        admin_mode = 1'b0;
    logic        dispense_ready = 1'b0;
    logic        change_ready = 1'b0;
    logic [11:0] credit;
    logic        dispense_valid;
    logic [1:0]  dispense_item;
    logic        change_valid;
    logic [1:0]  change_coin;
    logic [15:0] stock;
    logic        event_valid;
    logic [2:0]  event_code;

    int n_tests = 0;
    int n_fail  = 0;

    int price_t[4] = '{150, 200, 250, 300};
    int coin_t[3]  = '{500, 100, 50};

    int m_credit;
    int m_stock[4];
    int m_mode;
    int m_item;
    int q[$];
    logic m_evv;
    int m_evc;

    vending_controller dut (
        .clk            (clk),
        .rst            (rst),
        .coin_in        (coin_in),
        .sel            (sel),
        .cancel         (cancel),
        .admin_mode     (admin_mode),
        .dispense_ready (dispense_ready),
        .change_ready   (change_ready),
        .credit         (credit),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_coin    (change_coin),
        .stock          (stock),
        .event_valid    (event_valid),
        .event_code     (event_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
        m_mode = M_IDLE;
        m_item = 0;
        q.delete();
        m_evv = 1'b0;
        m_evc = 0;
    endtask

    task automatic model_step(input logic [2:0] c, input logic [3:0] s, input logic x,
                              input logic dr, input logic cr, input logic adm);
        int ev, i, amt;
        ev = 0;
        case (m_mode)
            M_IDLE: begin
                if (ADMIN_ON && adm) begin
                    m_mode = M_ADM;
                    ev = 7;
                end else if (x) begin
                    if (m_credit > 0) begin
                        amt = m_credit;
                        q.delete();
                        for (int k = 0; k < 3; k++) begin
                            while (amt >= coin_t[k]) begin
                                q.push_back(k);
                                amt -= coin_t[k];
                            end
                        end
                        if (q.size() > 0) m_mode = M_CHG;
                    end
                end else if (s != 0) begin
                    i = lowest(s);
                    if (m_stock[i] == 0) ev = 3;
                    else if (m_credit < price_t[i]) ev = 4;
                    else begin
                        m_credit -= price_t[i];
                        m_stock[i]--;
                        m_item = i;
                        m_mode = M_VEND;
                        ev = 2;
                    end
                end else if (c != 0) begin
                    i = lowest({1'b0, c});
                    if (m_credit + coin_t[i] <= 2000) begin
                        m_credit += coin_t[i];
                        ev = 1;
                    end else ev = 5;
                end
            end
            M_VEND: begin
                if (c != 0) ev = 5;
                if (dr) m_mode = M_IDLE;
            end
            M_CHG: begin
                if (c != 0) ev = 5;
                if (cr) begin
                    m_credit -= coin_t[q[0]];
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_mode = M_IDLE;
                        if (m_credit == 0) ev = 6;
                    end
                end
            end
            default: begin
                if (!adm) m_mode = M_IDLE;
                else if (x) m_credit = 0;
                else if (s != 0) begin
                    i = lowest(s);
                    if (m_stock[i] < 15) m_stock[i]++;
                end else if (c != 0) ev = 5;
            end
        endcase
        m_evv = (ev != 0);
        if (ev != 0) m_evc = ev;
    endtask

    task automatic check_all();
        chk("credit", credit, m_credit);
        for (int i = 0; i < 4; i++) chk($sformatf("stock%0d", i), stock[i*4 +: 4], m_stock[i]);
        chk("disp_valid", dispense_valid, m_mode == M_VEND);
        if (m_mode == M_VEND) chk("disp_item", dispense_item, m_item);
        chk("chg_valid", change_valid, m_mode == M_CHG);
        if (m_mode == M_CHG) chk("chg_coin", change_coin, q[0]);
        chk("ev_valid", event_valid, m_evv);
        chk("ev_code", event_code, m_evc);
    endtask

    task automatic cyc(input logic [2:0] c, input logic [3:0] s, input logic x,
                       input logic dr, input logic cr, input logic adm = 1'b0);
        coin_in = c;
        sel = s;
        cancel = x;
        dispense_ready = dr;
        change_ready = cr;
        admin_mode = adm;
        model_step(c, s, x, dr, cr, adm);
        @(posedge clk);
        #1;
        coin_in = '0;
        sel = '0;
        cancel = 1'b0;
        check_all();
    endtask

    task automatic rst_cyc();
        rst = 1'b0;
        coin_in = '0;
        sel = '0;
        cancel = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all();
    endtask

    initial begin
        // Reset state
        rst_cyc();
        chk("rst_credit", credit, 0);
        chk("rst_code", event_code, 0);
        chk("rst_stock", stock, 16'h5555);

        // Two 100 coins, then buy item 1 (200)
        cyc(3'b010, 4'b0, 0, 0, 0);
        cyc(3'b010, 4'b0, 0, 0, 0);
        chk("coin_credit200", credit, 200);
        chk("coin_ok_code", event_code, 1);
        cyc(3'b000, 4'b0010, 0, 0, 0);
        chk("vend_valid", dispense_valid, 1);
        chk("vend_item1", dispense_item, 1);
        chk("vend_credit0", credit, 0);
        chk("vend_stock1", stock[7:4], 4);
        for (int k = 0; k < 3; k++) cyc(3'b0, 4'b0, 0, 0, 0);
        chk("vend_held", dispense_valid, 1);
        cyc(3'b0, 4'b0, 0, 1, 0);
        chk("vend_done", dispense_valid, 0);
        cyc(3'b0, 4'b0, 0, 1, 0);
        chk("vend_single", stock[7:4], 4);

        // Insufficient funds
        cyc(3'b010, 4'b0, 0, 0, 0);
        cyc(3'b000, 4'b0001, 0, 0, 0);
        chk("no_funds_code", event_code, 4);
        chk("no_funds_credit", credit, 100);

        // Drain item 2 then sold out
        for (int k = 0; k < 3; k++) cyc(3'b001, 4'b0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(3'b000, 4'b0100, 0, 0, 0);
            cyc(3'b000, 4'b0000, 0, 1, 0);
        end
        chk("drain_stock2", stock[11:8], 0);
        cyc(3'b000, 4'b0100, 0, 0, 0);
        chk("sold_out_code", event_code, 3);
        chk("sold_out_credit", credit, 350);

        // Change for 650: coins 0,1,2 back-to-back
        for (int k = 0; k < 3; k++) cyc(3'b010, 4'b0, 0, 0, 0);
        chk("credit650", credit, 650);
        cyc(3'b0, 4'b0, 1, 0, 1);
        chk("chg_first", change_coin, 0);
        cyc(3'b0, 4'b0, 0, 0, 1);
        chk("chg_second", change_coin, 1);
        chk("chg_credit150", credit, 150);
        cyc(3'b0, 4'b0, 0, 0, 1);
        chk("chg_third", change_coin, 2);
        cyc(3'b0, 4'b0, 0, 0, 1);
        chk("chg_credit0", credit, 0);
        chk("chg_done_code", event_code, 6);
        chk("chg_done_valid", change_valid, 0);

        // Credit ceiling, then cancel beats coin
        for (int k = 0; k < 3; k++) cyc(3'b001, 4'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(3'b010, 4'b0, 0, 0, 0);
        cyc(3'b001, 4'b0, 0, 0, 0);
        chk("reject_code", event_code, 5);
        chk("reject_credit", credit, 1900);
        cyc(3'b001, 4'b0, 1, 0, 0);
        chk("cancel_wins_ev", event_valid, 0);
        chk("cancel_wins_credit", credit, 1900);
        cyc(3'b0, 4'b0, 0, 0, 1);
        chk("one_coin_credit", credit, 1400);

        // Reset mid-change
        change_ready = 1'b1;
        rst_cyc();
        chk("abort_credit", credit, 0);
        chk("abort_chg_valid", change_valid, 0);
        chk("abort_stock", stock, 16'h5555);
        change_ready = 1'b0;

        // Restock mode (or ignored admin_mode)
        cyc(3'b0, 4'b0, 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) cyc(3'b0, 4'b1000, 0, 0, 0, 1);
        chk("admin_stock3", stock[15:12], ADMIN_ON ? 15 : 5);
        cyc(3'b0, 4'b0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [2:0] c;
            logic [3:0] s;
            c = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b0;
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            cyc(c, s, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
